// File: rtl/trng_mram_pkg.sv
// Shared command encodings, sequencer states and burst range check for the
// MRAM TRNG/memory sequencer.
package trng_mram_pkg;

   typedef enum logic [1:0] {
      CMD_RNG     = 2'b00,
      CMD_SET_VAR = 2'b01,
      CMD_WRITE   = 2'b10,
      CMD_READ    = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_ACC,
      S_GAP,
      S_PHASE2,
      S_FIN
   } state_e;

   // True when the last beat of a burst starting at first lands past max_addr.
   // 32 bits is wide enough that first+beats-1 never wraps for any host address.
   function automatic logic range_bad(input logic [31:0] first,
                                      input logic [31:0] beats,
                                      input logic [31:0] max_addr);
      logic [31:0] last;
      last = first + beats - 32'd1;
      return last > max_addr;
   endfunction

endpackage

// File: rtl/trng_mram_beat_timer.sv
// Per-beat phase counter: PULSE_CYC access cycles followed by RECOV_CYC
// recovery cycles, repeating for as long as run stays high.
module trng_mram_beat_timer #(
   parameter int PULSE_CYC = 4,
   parameter int RECOV_CYC = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic run,
   output logic acc,
   output logic last_acc,
   output logic gap_end
);

   localparam int PER = PULSE_CYC + RECOV_CYC;
   localparam int CW  = (PER > 1) ? $clog2(PER) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                cnt <= '0;
      else if (!run || gap_end) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
   end

   assign acc      = run && (cnt < CW'(PULSE_CYC));
   assign last_acc = run && (cnt == CW'(PULSE_CYC - 1));
   assign gap_end  = run && (cnt == CW'(PER - 1));

endmodule

// File: rtl/trng_mram_seq.sv
// MRAM TRNG/memory sequencer: runs RNG, SET_VAR, WRITE and READ commands as
// bursts of BEATS DATA_W-bit accesses on the MRAM macro pins.
module trng_mram_seq
   import trng_mram_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int BEATS     = 18,
   parameter int ADDR_W    = 12,
   parameter int ROW_W     = 7,
   parameter int COL_W     = 4,
   parameter int MAX_ADDR  = 2047,
   parameter int PULSE_CYC = 4,
   parameter int RECOV_CYC = 2,
   parameter int DMODE_W   = 6,
   parameter int TMODE_W   = 9
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic [1:0]              cmd,
   input  logic [ADDR_W-1:0]       addr,
   input  logic [1:0]              detour_in,
   input  logic                    rp_sel_in,
   input  logic [DMODE_W-1:0]      dmode_write,
   input  logic [DMODE_W-1:0]      dmode_read,
   input  logic [TMODE_W-1:0]      trng_mode_in,
   input  logic                    data_trng,
   input  logic [DATA_W*BEATS-1:0] mem_in,
   input  logic [DATA_W-1:0]       mram_q,
   output logic                    csn,
   output logic                    wen,
   output logic [ROW_W-1:0]        row_addr,
   output logic [COL_W-1:0]        col_addr,
   output logic [1:0]              detour,
   output logic                    rp_sel,
   output logic [DMODE_W-1:0]      dmode,
   output logic [DATA_W-1:0]       data,
   output logic [TMODE_W-1:0]      trng_mode,
   output logic [DATA_W*BEATS-1:0] mem_out,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int BW = $clog2(BEATS + 1);
   localparam int SW = (BEATS > 1) ? $clog2(BEATS) : 1;

   state_e                         state, state_n;
   cmd_e                           cmd_q;
   logic [ADDR_W-1:0]              addr_q, loc;
   logic [BW-1:0]                  beat;
   logic                           ph2, err_q;
   logic [1:0]                     det_q;
   logic                           rp_q, seed_q;
   logic [DMODE_W-1:0]             dw_q, dr_q;
   logic [TMODE_W-1:0]             tm_q;
   logic [BEATS-1:0][DATA_W-1:0]   rbuf, win;
   logic [SW-1:0]                  beat_sel;
   logic                           run, acc, last_acc, gap_end;
   logic                           last_beat, rng_p1, writing, bad, in_acc;

   trng_mram_beat_timer #(
      .PULSE_CYC (PULSE_CYC),
      .RECOV_CYC (RECOV_CYC)
   ) u_timer (
      .clk      (clk),
      .rstn     (rstn),
      .run      (run),
      .acc      (acc),
      .last_acc (last_acc),
      .gap_end  (gap_end)
   );

   assign run       = (state == S_ACC) || (state == S_GAP) || (state == S_PHASE2);
   assign in_acc    = (state == S_ACC) && acc;
   assign last_beat = (beat == BW'(BEATS - 1));
   assign rng_p1    = (cmd_q == CMD_RNG) && !ph2;
   assign writing   = (cmd_q == CMD_WRITE) || rng_p1;
   assign bad       = range_bad(32'(addr_q), 32'(BEATS), 32'(MAX_ADDR));
   assign win       = mem_in;
   // beat reaches BEATS during the final recovery; clamp so the select stays in range
   assign beat_sel  = (beat < BW'(BEATS)) ? SW'(beat) : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      csn       = 1'b1;
      wen       = 1'b1;
      data      = '0;
      dmode     = '0;
      trng_mode = '0;
      case (state)
         S_IDLE:   if (start) state_n = (cmd_e'(cmd) == CMD_SET_VAR) ? S_FIN : S_CHECK;
         S_CHECK:  state_n = bad ? S_FIN : S_ACC;
         S_ACC:    if (last_acc) state_n = (last_beat && rng_p1) ? S_PHASE2 : S_GAP;
         S_GAP:    if (gap_end) state_n = (beat == BW'(BEATS)) ? S_FIN : S_ACC;
         S_PHASE2: if (gap_end) state_n = S_ACC;
         S_FIN:    state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
      if (run) dmode = writing ? dw_q : dr_q;
      if ((state == S_ACC || state == S_GAP) && rng_p1) trng_mode = tm_q;
      if (in_acc) begin
         csn = 1'b0;
         if (writing) begin
            wen  = 1'b0;
            data = rng_p1 ? {DATA_W{seed_q}} : win[beat_sel];
         end
      end
   end

   assign busy     = (state != S_IDLE);
   assign done     = (state == S_FIN);
   assign err      = (state == S_FIN) && err_q;
   assign detour   = det_q;
   assign rp_sel   = rp_q;
   assign row_addr = loc[ROW_W+COL_W-1:COL_W];
   assign col_addr = loc[COL_W-1:0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cmd_q   <= CMD_RNG;
         addr_q  <= '0;
         loc     <= '0;
         beat    <= '0;
         ph2     <= 1'b0;
         err_q   <= 1'b0;
         det_q   <= '0;
         rp_q    <= 1'b0;
         seed_q  <= 1'b0;
         dw_q    <= '0;
         dr_q    <= '0;
         tm_q    <= '0;
         rbuf    <= '0;
         mem_out <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               cmd_q  <= cmd_e'(cmd);
               addr_q <= addr;
               loc    <= addr;
               beat   <= '0;
               ph2    <= 1'b0;
               err_q  <= 1'b0;
               if (cmd_e'(cmd) == CMD_SET_VAR) begin
                  det_q  <= detour_in;
                  rp_q   <= rp_sel_in;
                  dw_q   <= dmode_write;
                  dr_q   <= dmode_read;
                  tm_q   <= trng_mode_in;
                  seed_q <= data_trng;
               end
            end
            S_CHECK: err_q <= bad;
            S_ACC: if (last_acc) begin
               if (!writing) rbuf[beat_sel] <= mram_q;
               // address moves as csn rises so it is settled a full cycle before the next fall
               if (last_beat && rng_p1) begin
                  beat <= '0;
                  ph2  <= 1'b1;
                  loc  <= addr_q;
               end else begin
                  beat <= beat + 1'b1;
                  loc  <= loc + 1'b1;
               end
            end
            S_GAP: if (gap_end && beat == BW'(BEATS) && cmd_q != CMD_WRITE) mem_out <= rbuf;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_trng_mram_seq.sv
// Randomized self-checking bench for trng_mram_seq against a beat-list model.
module tb_trng_mram_seq;

   localparam int NB = 18, P = 4, R = 2, MAXA = 2047;
   localparam logic [1:0] C_RNG = 2'b00, C_SET = 2'b01, C_WR = 2'b10, C_RD = 2'b11;

   logic         clk = 1'b0, rstn = 1'b0, start = 1'b0;
   logic [1:0]   cmd = '0;
   logic [11:0]  addr = '0;
   logic [1:0]   detour_in = '0;
   logic         rp_sel_in = 1'b0;
   logic [5:0]   dmode_write = '0, dmode_read = '0;
   logic [8:0]   trng_mode_in = '0;
   logic         data_trng = 1'b0;
   logic [143:0] mem_in = '0;
   logic [7:0]   mram_q = '0;
   logic         csn, wen, busy, done, err, rp_sel;
   logic [6:0]   row_addr;
   logic [3:0]   col_addr;
   logic [1:0]   detour;
   logic [5:0]   dmode;
   logic [7:0]   data;
   logic [8:0]   trng_mode;
   logic [143:0] mem_out;

   trng_mram_seq dut (
      .clk(clk), .rstn(rstn), .start(start), .cmd(cmd), .addr(addr),
      .detour_in(detour_in), .rp_sel_in(rp_sel_in), .dmode_write(dmode_write),
      .dmode_read(dmode_read), .trng_mode_in(trng_mode_in), .data_trng(data_trng),
      .mem_in(mem_in), .mram_q(mram_q), .csn(csn), .wen(wen), .row_addr(row_addr),
      .col_addr(col_addr), .detour(detour), .rp_sel(rp_sel), .dmode(dmode),
      .data(data), .trng_mode(trng_mode), .mem_out(mem_out), .busy(busy),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0]  row;
      logic [3:0]  col;
      logic        wen;
      logic [7:0]  data;
      logic [5:0]  dm;
      logic [8:0]  tm;
      logic [15:0] fall;
      logic [7:0]  len;
      logic        stable;
   } beat_t;

   beat_t got_q[$], exp_q[$];
   beat_t mb;
   int errors = 0, checks = 0;
   int pe = 0, t0 = 0, lowlen = 0, rd_idx = 0, done_cnt = 0, err_cnt = 0;
   int done_cyc, busy_len;
   logic prev_csn = 1'b1;
   logic [6:0] prow = '0;
   logic [3:0] pcol = '0;
   logic [7:0] rdv [0:63];

   // model of the configuration registers and the last returned word
   logic [1:0] m_det = '0;
   logic m_rp = 1'b0, m_seed = 1'b0;
   logic [5:0] m_dw = '0, m_dr = '0;
   logic [8:0] m_tm = '0;
   logic [143:0] m_mem = '0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) pe <= pe + 1;

   // Beat monitor: records every csn-low window and feeds read data per beat.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (!csn && prev_csn) begin
         mb.row = row_addr; mb.col = col_addr; mb.wen = wen; mb.data = data;
         mb.dm = dmode; mb.tm = trng_mode; mb.fall = 16'(pe - t0); mb.len = '0;
         mb.stable = (row_addr == prow) && (col_addr == pcol);
         got_q.push_back(mb);
         lowlen = 1;
         if (wen) begin
            mram_q = rdv[rd_idx % 64];
            rd_idx++;
         end
      end else if (!csn && got_q.size() > 0) begin
         lowlen++;
         mb = got_q[got_q.size()-1];
         if ({row_addr, col_addr, wen, data, dmode, trng_mode} !== {mb.row, mb.col, mb.wen, mb.data, mb.dm, mb.tm})
            got_q[got_q.size()-1].stable = 1'b0;
      end else if (csn && !prev_csn && got_q.size() > 0) begin
         got_q[got_q.size()-1].len = 8'(lowlen);
      end
      prev_csn = csn; prow = row_addr; pcol = col_addr;
   end

   task automatic do_cmd(input logic [1:0] c, input logic [11:0] a, input bit poke);
      int n;
      got_q.delete();
      rd_idx = 0;
      @(negedge clk);
      cmd = c; addr = a; start = 1'b1; t0 = pe;
      @(negedge clk);
      start = 1'b0;
      busy_len = 0;
      for (n = 1; n < 400; n++) begin
         if (busy) busy_len++;
         if (done) break;
         start = poke && (n == 20);
         if (start) cmd = C_WR;
         @(negedge clk);
      end
      start = 1'b0;
      done_cyc = n;
      @(negedge clk);
      chk("busy_after_done", busy, 1'b0);
   endtask

   // Expected behaviour derived from the command rules: beat list, latency, result word.
   task automatic expect_cmd(input logic [1:0] c, input logic [11:0] a, input int dc0, input int ec0);
      int bad, exp_cyc, idx, nph;
      bit wr;
      beat_t b;
      bad = (c != C_SET) && (int'(a) + NB - 1 > MAXA);
      nph = (c == C_RNG) ? 2 : 1;
      exp_q.delete();
      if (c == C_SET) begin
         m_det = detour_in; m_rp = rp_sel_in; m_dw = dmode_write;
         m_dr = dmode_read; m_tm = trng_mode_in; m_seed = data_trng;
      end else if (!bad) begin
         idx = 0;
         for (int ph = 0; ph < nph; ph++)
            for (int k = 0; k < NB; k++) begin
               wr = (c == C_WR) || (c == C_RNG && ph == 0);
               b.row = 7'((int'(a) + k) / 16);
               b.col = 4'((int'(a) + k) % 16);
               b.wen = !wr;
               b.data = !wr ? 8'h00 : (c == C_RNG) ? {8{m_seed}} : mem_in[8*k +: 8];
               b.dm = wr ? m_dw : m_dr;
               b.tm = (c == C_RNG && ph == 0) ? m_tm : 9'h0;
               b.fall = 16'(2 + (P + R) * idx);
               b.len = 8'(P);
               b.stable = 1'b1;
               exp_q.push_back(b);
               idx++;
            end
         if (c != C_WR)
            for (int k = 0; k < NB; k++) m_mem[8*k +: 8] = rdv[k];
      end
      exp_cyc = (c == C_SET) ? 1 : bad ? 2 : 2 + nph * NB * (P + R);
      chk("done_cycle", done_cyc, exp_cyc);
      chk("busy_len", busy_len, exp_cyc);
      chk("done_count", done_cnt - dc0, 1);
      chk("err_count", err_cnt - ec0, bad);
      chk("beat_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("beat%0d", i), got_q[i], exp_q[i]);
      chk("mem_out", mem_out, m_mem);
      chk("detour", detour, m_det);
      chk("rp_sel", rp_sel, m_rp);
   endtask

   task automatic run(input logic [1:0] c, input logic [11:0] a, input bit poke);
      int dc0, ec0;
      dc0 = done_cnt; ec0 = err_cnt;
      do_cmd(c, a, poke);
      expect_cmd(c, a, dc0, ec0);
   endtask

   task automatic fill_rdv();
      for (int i = 0; i < 64; i++) rdv[i] = 8'($urandom);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [11:0] ra;
      logic [1:0] rc;
      fill_rdv();
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_csn", csn, 1'b1);
      chk("rst_wen", wen, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_mem_out", mem_out, 144'h0);
      chk("rst_pins", {row_addr, col_addr, dmode, data, trng_mode, detour, rp_sel}, 0);
      chk("rst_no_done", done_cnt, 0);

      detour_in = 2'b10; rp_sel_in = 1'b1; dmode_write = 6'h3F; dmode_read = 6'h15;
      trng_mode_in = 9'h1A5; data_trng = 1'b1;
      run(C_SET, 12'd0, 1'b0);
      detour_in = '0; rp_sel_in = 1'b0; dmode_write = '0; dmode_read = '0;
      trng_mode_in = '0; data_trng = 1'b0;

      run(C_WR, 12'd3000, 1'b0);
      run(C_WR, 12'd2031, 1'b0);
      run(C_WR, 12'd2030, 1'b0);

      mem_in = 144'h987654321123456789987654321123456789;
      run(C_WR, 12'd30, 1'b0);
      chk("wr30_first_beat", {got_q[0].row, got_q[0].col, got_q[0].data}, {7'd1, 4'd14, 8'h89});

      fill_rdv();
      rdv[0] = 8'h12; rdv[1] = 8'h34; rdv[2] = 8'h56;
      run(C_RD, 12'd30, 1'b1);
      chk("rd30_low_bytes", mem_out[23:0], 24'h563412);

      fill_rdv();
      run(C_RNG, 12'd0, 1'b0);

      for (int it = 0; it < 25; it++) begin
         rc = 2'($urandom_range(0, 3));
         ra = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                                          : 12'($urandom_range(0, MAXA - NB + 1));
         detour_in = 2'($urandom); rp_sel_in = 1'($urandom); data_trng = 1'($urandom);
         dmode_write = 6'($urandom); dmode_read = 6'($urandom); trng_mode_in = 9'($urandom);
         mem_in = {16'($urandom), $urandom, $urandom, $urandom, $urandom};
         fill_rdv();
         run(rc, ra, it[0]);
      end

      // abort an RNG burst by reset during beat 5
      got_q.delete();
      rd_idx = 0;
      n = done_cnt;
      @(negedge clk);
      cmd = C_RNG; addr = 12'd0; start = 1'b1; t0 = pe;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 400 && got_q.size() < 6; i++) @(negedge clk);
      chk("abort_reached_beat5", got_q.size(), 6);
      rstn = 1'b0;
      #1;
      chk("abort_csn", csn, 1'b1);
      chk("abort_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      chk("abort_no_done", done_cnt - n, 0);
      rstn = 1'b1;
      m_det = '0; m_rp = 1'b0; m_mem = '0;
      repeat (2) @(negedge clk);
      chk("abort_cfg_clear", {detour, rp_sel}, {m_det, m_rp});
      chk("abort_mem_out", mem_out, m_mem);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
